h75_frame_loader: RTL
=====================

Name: h75_frame_loader

Overview:
Upstream feeder for the HUB75 display engine. It accepts a stream of 32-bit pixel words pushed from the APB control/status block and buffers them in a small FIFO. It drains them into the display engine's frame memory write port (wr_en/wr_addr/wr_data) with auto-incrementing addresses, tracking row/column position against the runtime pixels_per_row. It wraps at end of frame and reports frame completion and overflow.

Parameters:
ADDR_W, 15, frame-memory word address width (matches wr_addr)
DATA_W, 32, pixel word width
PPR_W, 9, width of pixels_per_row
ROWS, 32, scan rows per frame buffer (row counter wraps at ROWS-1)
FIFO_DEPTH, 4, input buffer depth (power of two, >=2)

Ports:
clk  in  1  system clock (PCLK domain)
reset  in  1  synchronous reset, active-high
pixels_per_row  in  PPR_W  words per row; sampled only at frame start; 0 is treated as 1
sof  in  1  start-of-frame pulse; flushes FIFO and resets position to address 0
in_valid  in  1  pixel word present
in_data  in  DATA_W  pixel word
in_ready  out  1  FIFO not full
mem_wr  out  1  frame-memory write strobe, one word per cycle
mem_waddr  out  ADDR_W  frame-memory word address
mem_data  out  DATA_W  frame-memory write data
frame_done  out  1  one-cycle pulse with the write of the last word of a frame
overflow  out  1  sticky; set when in_valid is high while in_ready is low; cleared by sof or reset
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (sync, active-high): FIFO empty, level=0, in_ready=1, mem_wr=0, mem_waddr=0, mem_data=0, frame_done=0, overflow=0, col=0, row=0, ppr_q=max(pixels_per_row,1).
- Input handshake: a word is accepted when in_valid && in_ready. in_ready=(level!=FIFO_DEPTH). Data is never dropped silently: a push while full sets overflow and the word is discarded.
- Drain: when FIFO is non-empty, pop one word per cycle. Registered output: mem_wr=1 on the cycle after the pop, with mem_data=popped word and mem_waddr=address at time of pop. Latency from accepted push to mem_wr is 2 cycles when the FIFO is empty.
- Simultaneous push and pop while full is allowed: level is unchanged and in_ready stays 0 that cycle. Full is evaluated before the pop.
- Addressing: addr increments by 1 per pop. col counts 0..ppr_q-1. At col==ppr_q-1, col returns to 0 and row increments. At col==ppr_q-1 && row==ROWS-1, that write asserts frame_done (aligned with its mem_wr), and addr, col and row all return to 0. ppr_q is reloaded from pixels_per_row at this wrap.
- addr width: addr wraps modulo 2^ADDR_W. Configurations with ROWS*ppr > 2^ADDR_W are unsupported.
- FSM: IDLE (FIFO empty, mem_wr=0) -> STREAM (pop each cycle while non-empty) -> IDLE when empty. Any state -> IDLE on sof.
- sof: takes effect the same cycle. It clears the FIFO, level, col, row, addr and overflow, and reloads ppr_q. Any in-flight registered write from the previous cycle still completes. A push coincident with sof is accepted as word 0 of the new frame.
- Reset mid-frame behaves like sof plus clearing of mem_* outputs. No partial frame_done is issued.

Decomposition:
- Shared package h75_pkg: ADDR_W, DATA_W, PPR_W, ROWS defaults, and the loader FSM state typedef (IDLE, STREAM). These are shared with the display engine and APB block.
- One sub-module, h75_sync_fifo: a parameterised synchronous FIFO (push/pop/full/empty/level). It is reusable by the display engine's line buffering.

Test Plan:
- Reset then single push 0xDEADBEEF -> mem_wr high exactly 2 cycles later with mem_waddr=0, mem_data=0xDEADBEEF; level returns to 0.
- pixels_per_row=4, ROWS=2, push 8 words back-to-back -> addresses 0..7 on consecutive cycles; frame_done coincides with addr 7; the next push writes addr 0.
- Hold the drain stall-free and push 6 words in 6 cycles with FIFO_DEPTH=4 -> in_ready never drops and overflow stays 0. Then force in_valid on a full FIFO (via simultaneous-full test hook, no pop) -> overflow=1 and the word is absent from memory writes.
- sof asserted after 3 words of a frame with 2 still buffered -> buffered words are discarded, the next accepted word is written at addr 0, and overflow is cleared.
- pixels_per_row changed from 4 to 8 mid-frame -> the current frame still wraps at 4 columns; the following frame uses 8. pixels_per_row=0 -> each row is 1 word.
- Reset asserted during a streaming burst -> next cycle mem_wr=0, level=0, in_ready=1, and the first post-reset word goes to addr 0.

Source files
------------

// File: rtl/h75_pkg.sv
// rtl/h75_pkg.sv - shared HUB75 widths and loader FSM state type
// Shared by the frame loader, display engine and APB control block.
package h75_pkg;

    localparam int H75_ADDR_W = 15;  // frame-memory word address width
    localparam int H75_DATA_W = 32;  // pixel word width
    localparam int H75_PPR_W  = 9;   // pixels_per_row width
    localparam int H75_ROWS   = 32;  // scan rows per frame buffer

    typedef enum logic {
        IDLE,
        STREAM
    } loader_state_t;

endpackage

// File: rtl/h75_frame_loader_if.sv
// rtl/h75_frame_loader_if.sv - pixel input stream and frame-memory write port
// in_valid/in_data/in_ready : pixel words into the loader
// mem_wr/mem_waddr/mem_data : one-word-per-cycle frame-memory write port
// master: feeder / memory side, slave: loader side
interface h75_frame_loader_if #(
    parameter int ADDR_W = h75_pkg::H75_ADDR_W,
    parameter int DATA_W = h75_pkg::H75_DATA_W
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_wr,
        input  mem_waddr,
        input  mem_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_wr,
        output mem_waddr,
        output mem_data
    );

endinterface

// File: rtl/h75_sync_fifo.sv
// rtl/h75_sync_fifo.sv - parameterised synchronous FIFO with flush
// clk/reset : clock, synchronous active-high reset
// flush     : empties the FIFO; a push in the same cycle becomes the only entry
// push/push_data : write request; taken when not full, or when full and popping
// pop/pop_data   : read request; pop_data shows the head entry combinationally
// full/empty/level : occupancy status
module h75_sync_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_idx;
    logic              do_push;
    logic              do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty && !flush;
    // Full is judged before the pop, so a full FIFO that pops this cycle
    // can still take the incoming word without changing its level.
    assign do_push  = push && (flush || !full || do_pop);
    assign wr_idx   = flush ? '0 : wr_ptr;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? PTR_W'(1) : '0;
            level  <= do_push ? LVL_W'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/h75_frame_loader.sv
// rtl/h75_frame_loader.sv - buffers pixel words and writes them into frame memory
// clk/reset      : clock, synchronous active-high reset
// pixels_per_row : row length, sampled at frame start (0 acts as 1)
// sof            : start of frame; flushes the buffer and restarts at address 0
// drain_hold     : pauses the drain so the buffer can fill
// bus (slave)    : pixel input stream and frame-memory write port
// frame_done     : pulses with the write of the last word of a frame
// overflow       : sticky, a word arrived while the buffer was full and not draining
// level          : buffer occupancy
module h75_frame_loader
    import h75_pkg::*;
#(
    parameter  int ADDR_W     = H75_ADDR_W,
    parameter  int DATA_W     = H75_DATA_W,
    parameter  int PPR_W      = H75_PPR_W,
    parameter  int ROWS       = H75_ROWS,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PPR_W-1:0]  pixels_per_row,
    input  logic              sof,
    input  logic              drain_hold,
    h75_frame_loader_if.slave bus,
    output logic              frame_done,
    output logic              overflow,
    output logic [LVL_W-1:0]  level
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    loader_state_t     state;
    loader_state_t     state_next;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] pop_data;
    logic [PPR_W-1:0]  ppr_in;
    logic [PPR_W-1:0]  ppr_q;
    logic [PPR_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic              col_last;
    logic              row_last;

    assign ppr_in       = (pixels_per_row == '0) ? PPR_W'(1) : pixels_per_row;
    assign col_last     = (col == ppr_q - PPR_W'(1));
    assign row_last     = (row == ROW_W'(ROWS - 1));
    assign bus.in_ready = !fifo_full;

    h75_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (sof),
        .push      (bus.in_valid),
        .push_data (bus.in_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Both states pop whenever data is buffered so the first word of a
    // burst leaves the FIFO the cycle after it lands.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !drain_hold) begin
                    pop        = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (fifo_empty || drain_hold) begin
                    state_next = IDLE;
                end else begin
                    pop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (sof) begin
            pop        = 1'b0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_wr    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_data  <= '0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            col           <= '0;
            row           <= '0;
            addr          <= '0;
            ppr_q         <= ppr_in;
        end else begin
            bus.mem_wr <= pop;
            frame_done <= pop && col_last && row_last;
            if (pop) begin
                bus.mem_waddr <= addr;
                bus.mem_data  <= pop_data;
            end
            if (sof) begin
                col      <= '0;
                row      <= '0;
                addr     <= '0;
                ppr_q    <= ppr_in;
                overflow <= 1'b0;
            end else begin
                // A full FIFO that pops this cycle still takes the word.
                if (bus.in_valid && fifo_full && !pop) begin
                    overflow <= 1'b1;
                end
                if (pop) begin
                    if (col_last) begin
                        col <= '0;
                        if (row_last) begin
                            row   <= '0;
                            addr  <= '0;
                            ppr_q <= ppr_in;
                        end else begin
                            row  <= row + ROW_W'(1);
                            addr <= addr + ADDR_W'(1);
                        end
                    end else begin
                        col  <= col + PPR_W'(1);
                        addr <= addr + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule
